// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the datapath and the 256 x 64-bit data memory.
// Handles B/H/W/D loads and stores; partial stores read-modify-write, misaligned requests error out.
module lsu_mem_ctrl #(
   parameter int Nbits = 64,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [Nbits-1:0] req_addr,
   input  logic [Nbits-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [Nbits-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic [Nbits-1:0] mem_address,
   output logic [Nbits-1:0] mem_w_data,
   input  logic [Nbits-1:0] mem_r_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t           state_q, state_d;
   logic             we_q, we_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [AW+2:0]    addr_q, addr_d;
   logic [Nbits-1:0] wdata_q, wdata_d;
   logic [Nbits-1:0] rbuf_q, rbuf_d;
   logic [Nbits-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             misaligned;
   logic [5:0]       laneShift;
   logic [Nbits-1:0] sizeMask, laneMask, mergeData, shifted, extData;
   logic             unusedBits;

   // Address bits above the memory range wrap away.
   assign unusedBits = ^req_addr[Nbits-1:AW+3];

   always_comb begin
      case (req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
   end

   // Lane mask/merge for stores and shift/extend for loads, both keyed off the latched request.
   always_comb begin
      laneShift = {addr_q[2:0], 3'b000};
      case (size_q)
         2'd0:    sizeMask = {{(Nbits-8){1'b0}},  {8{1'b1}}};
         2'd1:    sizeMask = {{(Nbits-16){1'b0}}, {16{1'b1}}};
         2'd2:    sizeMask = {{(Nbits-32){1'b0}}, {32{1'b1}}};
         default: sizeMask = {Nbits{1'b1}};
      endcase
      laneMask  = sizeMask << laneShift;
      mergeData = (rbuf_q & ~laneMask) | ((wdata_q & sizeMask) << laneShift);
      shifted   = mem_r_data >> laneShift;
      case (size_q)
         2'd0:    extData = {{(Nbits-8){~uns_q & shifted[7]}},   shifted[7:0]};
         2'd1:    extData = {{(Nbits-16){~uns_q & shifted[15]}}, shifted[15:0]};
         2'd2:    extData = {{(Nbits-32){~uns_q & shifted[31]}}, shifted[31:0]};
         default: extData = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr[AW+2:0];
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = misaligned;
               if (misaligned)
                  state_d = RESP;
               else if (req_we && req_size == 2'd3)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            rbuf_d = mem_r_data;
            if (we_q) begin
               state_d = WR;
            end else begin
               rdata_d = extData;
               state_d = RESP;
            end
         end
         WR:   state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // The write enable is gated by reset so a reset landing in WR never commits the store.
   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign mem_r_en    = (state_q == RD);
   assign mem_w_en    = (state_q == WR) & ~rst;
   assign mem_address = (state_q == RD || state_q == WR) ?
                        {{(Nbits-AW){1'b0}}, addr_q[AW+2:3]} : '0;
   assign mem_w_data  = (state_q == WR) ? mergeData : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-level reference model of the data memory.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;
   logic        mem_r_en, mem_w_en;
   logic [63:0] mem_address, mem_w_data, mem_r_data;

   logic [63:0] tbMem  [256];
   logic [63:0] refMem [256];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.Nbits(64), .AW(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .mem_address(mem_address), .mem_w_data(mem_w_data),
      .mem_r_data(mem_r_data)
   );

   // Memory environment: combinational read, write on posedge
   assign mem_r_data = tbMem[mem_address[7:0]];
   always @(posedge clk) if (mem_w_en) tbMem[mem_address[7:0]] <= mem_w_data;

   function automatic int wordIdx(input logic [63:0] addr);
      return int'((addr >> 3) % 256);
   endfunction

   function automatic bit refMisaligned(input logic [63:0] addr, input logic [1:0] size);
      int nb = 1 << size;
      return (int'(addr % 8) % nb) != 0;
   endfunction

   function automatic logic [63:0] refLoad(input logic [63:0] addr, input logic [1:0] size,
                                           input logic uns);
      logic [63:0] word = refMem[wordIdx(addr)];
      int off = int'(addr % 8);
      int nb = 1 << size;
      logic [63:0] v = 0;
      for (int i = 0; i < nb; i++)
         v = v | (((word >> (8 * (off + i))) & 64'hFF) << (8 * i));
      if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'h0 << (8 * nb));
      return v;
   endfunction

   function automatic logic [63:0] refStoreWord(input logic [63:0] addr, input logic [1:0] size,
                                                input logic [63:0] wdata);
      logic [63:0] word = refMem[wordIdx(addr)];
      int off = int'(addr % 8);
      int nb = 1 << size;
      for (int i = 0; i < nb; i++)
         for (int b = 0; b < 8; b++)
            word[8*(off+i)+b] = wdata[8*i+b];
      return word;
   endfunction

   function automatic int refLatency(input bit we, input logic [1:0] size, input bit mis);
      if (mis) return 1;
      if (!we) return 2;
      if (size == 2'd3) return 2;
      return 3;
   endfunction

   task automatic applyStimulus(input bit we, input logic [1:0] size, input bit uns,
                                input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                                output logic [63:0] rdata, output logic err, output int lat,
                                output bit sawR, output bit sawW, output logic [63:0] wSeen,
                                output bit stable, output bit readyLow);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; sawR = 0; sawW = 0; wSeen = '0;
      while (!rsp_valid && lat < 12) begin
         if (mem_r_en) sawR = 1;
         if (mem_w_en) begin sawW = 1; wSeen = mem_w_data; end
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         errors++; checks++;
         $display("[TB] FAIL timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
      end
      rdata = rsp_rdata; err = rsp_err;
      stable = 1; readyLow = !req_ready;
      if (mem_r_en || mem_w_en) begin sawR |= mem_r_en; sawW |= mem_w_en; end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err) stable = 0;
         if (req_ready) readyLow = 0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_r_en, mem_w_en} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got rdy/vld/err/ren/wen=%b, required 10000",
                  {req_ready, rsp_valid, rsp_err, mem_r_en, mem_w_en});
      end
      checks++;
      if (rsp_rdata !== 64'h0 || mem_address !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: rdata=%h addr=%h, required 0", rsp_rdata, mem_address);
      end
      rst = 1'b0;
   endtask

   task automatic test_load_byte();
      logic [63:0] rd, ws; logic er; int lat; bit sr, sw, st, rl;
      applyStimulus(0, 2'd0, 0, 64'h10, 64'h0, 0, rd, er, lat, sr, sw, ws, st, rl);
      checks++;
      if (rd !== 64'hFFFF_FFFF_FFFF_FF88 || er !== 1'b0 || lat != 2) begin
         errors++;
         $display("[TB] FAIL lb_signed: rdata=%h err=%b lat=%0d, required ffffffffffffff88 0 2",
                  rd, er, lat);
      end
      applyStimulus(0, 2'd0, 1, 64'h10, 64'h0, 0, rd, er, lat, sr, sw, ws, st, rl);
      checks++;
      if (rd !== 64'h88 || er !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lb_unsigned: rdata=%h err=%b, required 88 0", rd, er);
      end
   endtask

   task automatic test_store_half();
      logic [63:0] rd, ws; logic er; int lat; bit sr, sw, st, rl;
      applyStimulus(1, 2'd1, 0, 64'h12, 64'h1234_BEEF, 0, rd, er, lat, sr, sw, ws, st, rl);
      refMem[2] = refStoreWord(64'h12, 2'd1, 64'h1234_BEEF);
      checks++;
      if (ws !== 64'h1122_3344_BEEF_7788 || !sr || !sw || lat != 3 || rd !== 64'h0) begin
         errors++;
         $display("[TB] FAIL sh_rmw: wdata=%h ren=%b wen=%b lat=%0d rdata=%h, required 11223344beef7788 1 1 3 0",
                  ws, sr, sw, lat, rd);
      end
      applyStimulus(0, 2'd3, 1, 64'h10, 64'h0, 0, rd, er, lat, sr, sw, ws, st, rl);
      checks++;
      if (rd !== 64'h1122_3344_BEEF_7788 || lat != 2) begin
         errors++;
         $display("[TB] FAIL ld_after_sh: rdata=%h lat=%0d, required 11223344beef7788 2", rd, lat);
      end
   endtask

   task automatic test_misaligned();
      logic [63:0] rd, ws; logic er; int lat; bit sr, sw, st, rl;
      applyStimulus(0, 2'd2, 0, 64'h12, 64'h0, 0, rd, er, lat, sr, sw, ws, st, rl);
      checks++;
      if (er !== 1'b1 || rd !== 64'h0 || sr || sw || lat != 1) begin
         errors++;
         $display("[TB] FAIL misaligned: err=%b rdata=%h ren=%b wen=%b lat=%0d, required 1 0 0 0 1",
                  er, rd, sr, sw, lat);
      end
   endtask

   task automatic test_store_d_wrap();
      logic [63:0] rd, ws; logic er; int lat; bit sr, sw, st, rl;
      applyStimulus(1, 2'd3, 0, 64'h818, 64'hDEAD_BEEF_CAFE_F00D, 0, rd, er, lat, sr, sw, ws, st, rl);
      refMem[3] = 64'hDEAD_BEEF_CAFE_F00D;
      checks++;
      if (sr || !sw || lat != 2 || tbMem[3] !== 64'hDEAD_BEEF_CAFE_F00D) begin
         errors++;
         $display("[TB] FAIL sd_wrap: ren=%b wen=%b lat=%0d word3=%h, required 0 1 2 deadbeefcafef00d",
                  sr, sw, lat, tbMem[3]);
      end
   endtask

   task automatic test_back_pressure();
      logic [63:0] rd, ws, exp; logic er; int lat; bit sr, sw, st, rl;
      exp = refLoad(64'h1C, 2'd2, 0);
      applyStimulus(0, 2'd2, 0, 64'h1C, 64'h0, 3, rd, er, lat, sr, sw, ws, st, rl);
      checks++;
      if (!st || !rl || rd !== exp) begin
         errors++;
         $display("[TB] FAIL back_pressure: stable=%b readyLow=%b rdata=%h, required 1 1 %h",
                  st, rl, rd, exp);
      end
   endtask

   task automatic test_reset_in_wr();
      logic [63:0] orig = tbMem[5];
      logic [63:0] wd = {56'h0, ~orig[15:8]};
      bit wenBefore, wenAfter;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 64'h29; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      wenBefore = mem_w_en;
      rst = 1'b1;
      #1;
      wenAfter = mem_w_en;
      checks++;
      if (!wenBefore || wenAfter) begin
         errors++;
         $display("[TB] FAIL rst_wr_wen: wen before/after rst=%b%b, required 10", wenBefore, wenAfter);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (tbMem[5] !== orig || !req_ready || rsp_valid) begin
         errors++;
         $display("[TB] FAIL rst_wr_state: word5=%h rdy=%b vld=%b, required %h 1 0",
                  tbMem[5], req_ready, rsp_valid, orig);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rsp_valid || tbMem[5] !== orig) begin
         errors++;
         $display("[TB] FAIL rst_wr_drop: vld=%b word5=%h, required 0 %h", rsp_valid, tbMem[5], orig);
      end
   endtask

   task automatic test_random();
      logic [63:0] rd, ws, addr, wd, expRd; logic er; int lat; bit sr, sw, st, rl;
      bit we, uns, mis; logic [1:0] size; int nb, off;
      for (int n = 0; n < 60; n++) begin
         we   = $urandom_range(0, 1);
         uns  = $urandom_range(0, 1);
         size = 2'($urandom_range(0, 3));
         nb   = 1 << size;
         off  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : nb * $urandom_range(0, 8 / nb - 1);
         addr = ({32'($urandom), 32'($urandom)} << 11) | (64'($urandom_range(0, 7)) << 3) | 64'(off);
         wd   = {32'($urandom), 32'($urandom)};
         mis  = refMisaligned(addr, size);
         expRd = (mis || we) ? 64'h0 : refLoad(addr, size, uns);
         applyStimulus(we, size, uns, addr, wd, 0, rd, er, lat, sr, sw, ws, st, rl);
         if (we && !mis) refMem[wordIdx(addr)] = refStoreWord(addr, size, wd);
         checks++;
         if (rd !== expRd || er !== mis || lat != refLatency(we, size, mis)) begin
            errors++;
            $display("[TB] FAIL rand_%0d: we=%b sz=%0d addr=%h rdata=%h err=%b lat=%0d, required %h %b %0d",
                     n, we, size, addr, rd, er, lat, expRd, mis, refLatency(we, size, mis));
         end
      end
      begin
         int bad = 0;
         for (int i = 0; i < 256; i++) if (tbMem[i] !== refMem[i]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL mem_image: %0d words differ from model, required 0", bad);
         end
      end
   endtask

   initial begin
      req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
      req_addr = 0; req_wdata = 0; rsp_ready = 0; rst = 1;
      for (int i = 0; i < 256; i++) begin
         tbMem[i]  = {32'($urandom), 32'($urandom)};
         refMem[i] = tbMem[i];
      end
      tbMem[2]  = 64'h1122_3344_5566_7788;
      refMem[2] = 64'h1122_3344_5566_7788;
      test_reset();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_store_d_wrap();
      test_back_pressure();
      test_reset_in_wr();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
